// File: rtl/stack_unit_pkg.sv
// Shared definitions for the stack unit's level-transition handshake.
// Word width, FIFO depth and the sender's handshake state encoding.
package stack_unit_pkg;

  localparam int WORD_WIDTH    = 32;
  localparam int HS_FIFO_DEPTH = 4;

  // The sender state is exactly the pending bit (req_out ^ ack_q).
  typedef enum logic {
    HS_IDLE = 1'b0,
    HS_WAIT = 1'b1
  } hs_state_t;

  function automatic hs_state_t hs_state_of(input logic req, input logic ack);
    return (req ^ ack) ? HS_WAIT : HS_IDLE;
  endfunction

endpackage

// File: rtl/fifo_sincrona.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two so the
// pointers wrap by natural overflow.
module fifo_sincrona
  import stack_unit_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int DEPTH = HS_FIFO_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  // Storage is not reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/trasmettitore_transizione.sv
// Sender end of the level-transition handshake: buffers producer words and
// announces each one by toggling req_out, waiting for the matching ack toggle.
//
//  state   | meaning
//  --------+----------------------------------------------------------
//  HS_IDLE | req_out == ack_q; sends the FIFO head if one is available
//  HS_WAIT | req_out != ack_q; data_out and req_out held for receiver
module trasmettitore_transizione
  import stack_unit_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int DEPTH = HS_FIFO_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         data_out,
  output logic                     req_out,
  input  logic                     ack_in,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     proto_err
);

  logic             ack_q;
  logic             pending;
  hs_state_t        state;
  logic             send;
  logic             req_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic             err_nxt;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rd_data;

  fifo_sincrona #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (in_valid),
    .wr_data (in_data),
    .pop     (send),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (count)
  );

  // Full is decided from count alone, so a same-cycle send never frees a slot.
  assign in_ready = ~fifo_full;
  assign pending  = req_out ^ ack_q;
  assign busy     = pending;
  assign state    = hs_state_of(req_out, ack_q);

  always_comb begin
    send     = 1'b0;
    req_nxt  = req_out;
    data_nxt = data_out;
    err_nxt  = proto_err;
    case (state)
      HS_IDLE: begin
        if (!fifo_empty) begin
          send     = 1'b1;
          req_nxt  = ~req_out;
          data_nxt = fifo_rd_data;
        end
        // An ack edge with nothing outstanding leaves the pair out of step for good.
        if (ack_in != ack_q) err_nxt = 1'b1;
      end
      HS_WAIT: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ack_q     <= 1'b0;
      req_out   <= 1'b0;
      data_out  <= '0;
      proto_err <= 1'b0;
    end else begin
      ack_q     <= ack_in;
      req_out   <= req_nxt;
      data_out  <= data_nxt;
      proto_err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_trasmettitore_transizione.sv
// Directed bench for trasmettitore_transizione: hand-computed expectations at
// each step, plus an echoing receiver for the wrap-around ordering run.
module tb_trasmettitore_transizione;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_out;
  logic             req_out;
  logic             ack_in;
  logic             busy;
  logic [CW-1:0]    count;
  logic             proto_err;

  logic             man_ack;
  logic             echo_ack;
  logic             echo_en;
  logic [WIDTH-1:0] rx_q[$];

  int total = 0;
  int bad   = 0;

  assign ack_in = echo_en ? echo_ack : man_ack;

  trasmettitore_transizione #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .req_out   (req_out),
    .ack_in    (ack_in),
    .busy      (busy),
    .count     (count),
    .proto_err (proto_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Echoing receiver: consumes a pending word on the falling edge.
  initial begin
    echo_ack = 1'b0;
    forever begin
      @(negedge clock);
      if (echo_en && (req_out !== echo_ack)) begin
        rx_q.push_back(data_out);
        echo_ack = req_out;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [WIDTH-1:0] w [9];
  logic [WIDTH-1:0] seq [12];

  initial begin
    int n;
    int budget;
    logic accepted;

    w[0] = 32'h1111_0001; w[1] = 32'h2222_0002; w[2] = 32'h3333_0003;
    w[3] = 32'h4444_0004; w[4] = 32'h5555_0005; w[5] = 32'h6666_0006;
    w[6] = 32'h7777_0007; w[7] = 32'h8888_0008; w[8] = 32'hDEAD_BEEF;
    for (int i = 0; i < 12; i++) seq[i] = 32'hC0DE_0000 + 32'(i * 17 + 3);

    reset = 1'b1; in_data = '0; in_valid = 1'b0; man_ack = 1'b0; echo_en = 1'b0;
    #1;
    check("rst_req", req_out, 1'b0);
    check("rst_data", data_out, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_count", count, '0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_err", proto_err, 1'b0);
    step(); step();
    reset = 1'b0;
    step();

    // Single word, receiver idle.
    in_valid = 1'b1; in_data = 32'hA5A5_A5A5;
    step();
    in_valid = 1'b0;
    check("t2_count_e1", count, 1);
    check("t2_req_e1", req_out, 1'b0);
    step();
    check("t2_req_e2", req_out, 1'b1);
    check("t2_data_e2", data_out, 32'hA5A5_A5A5);
    check("t2_busy_e2", busy, 1'b1);
    check("t2_count_e2", count, 0);
    step();
    check("t2_busy_e3", busy, 1'b1);
    man_ack = 1'b1;
    step();
    check("t2_busy_e4", busy, 1'b0);
    check("t2_err_e4", proto_err, 1'b0);

    // Five back-to-back pushes with no ack.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = w[i];
      step();
    end
    in_valid = 1'b0;
    check("t3_count_full", count, 4);
    check("t3_in_ready", in_ready, 1'b0);
    check("t3_req", req_out, 1'b0);
    check("t3_data_w0", data_out, w[0]);
    in_valid = 1'b1; in_data = w[8];
    step();
    in_valid = 1'b0;
    check("t3_full_refused", count, 4);

    man_ack = 1'b0;
    step();
    check("t3_idle_after_ack", busy, 1'b0);
    step();
    check("t3_data_w1", data_out, w[1]);
    check("t3_req_w1", req_out, 1'b1);
    check("t3_count_w1", count, 3);
    man_ack = 1'b1;
    step(); step();
    check("t3_data_w2", data_out, w[2]);
    check("t3_count_w2", count, 2);

    // Push and send together at count=2.
    man_ack = 1'b0;
    step();
    in_valid = 1'b1; in_data = w[5];
    step();
    check("t4_pushsend_count", count, 2);
    check("t4_pushsend_data", data_out, w[3]);
    in_data = w[6];
    step();
    in_data = w[7];
    step();
    in_valid = 1'b0;
    check("t4_count4", count, 4);
    check("t4_in_ready0", in_ready, 1'b0);
    // Send at full with a push offered: the push is refused.
    man_ack = 1'b1;
    step();
    in_valid = 1'b1; in_data = w[8];
    step();
    in_valid = 1'b0;
    check("t4_full_send_count", count, 3);
    check("t4_full_send_data", data_out, w[4]);
    check("t4_in_ready1", in_ready, 1'b1);

    // Reset mid-cycle, mid-transfer.
    #2;
    reset = 1'b1; man_ack = 1'b0;
    #1;
    check("t1_mid_req", req_out, 1'b0);
    check("t1_mid_data", data_out, '0);
    check("t1_mid_count", count, '0);
    check("t1_mid_busy", busy, 1'b0);
    check("t1_mid_in_ready", in_ready, 1'b1);
    step();
    reset = 1'b0;
    step();

    // Wrap-around with an echoing receiver.
    echo_en = 1'b1;
    n = 0;
    budget = 0;
    while (n < 12 && budget < 300) begin
      in_valid = 1'b1; in_data = seq[n];
      accepted = in_ready;
      step();
      if (accepted) n++;
      budget++;
    end
    in_valid = 1'b0;
    check("t5_all_pushed", n, 12);
    budget = 0;
    while (rx_q.size() < 12 && budget < 300) begin
      step();
      budget++;
    end
    check("t5_rx_size", rx_q.size(), 12);
    for (int i = 0; i < 12; i++) begin
      if (i < rx_q.size()) check($sformatf("t5_rx_%0d", i), rx_q[i], seq[i]);
    end
    step(); step();
    check("t5_count_end", count, 0);
    check("t5_busy_end", busy, 1'b0);
    check("t5_req_end", req_out, 1'b0);

    // Ack toggle with nothing pending.
    echo_en = 1'b0; man_ack = 1'b0;
    step();
    check("t6_err_before", proto_err, 1'b0);
    man_ack = 1'b1;
    step();
    check("t6_err_set", proto_err, 1'b1);
    check("t6_no_send", req_out, 1'b0);
    in_valid = 1'b1; in_data = 32'h0BAD_F00D;
    step();
    in_valid = 1'b0;
    step(); step();
    check("t6_blocked_req", req_out, 1'b0);
    check("t6_blocked_count", count, 1);
    man_ack = 1'b0;
    step(); step();
    check("t6_resume_req", req_out, 1'b1);
    check("t6_resume_data", data_out, 32'h0BAD_F00D);
    check("t6_err_sticky", proto_err, 1'b1);
    reset = 1'b1;
    #1;
    check("t6_err_cleared", proto_err, 1'b0);
    step();
    reset = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
